// File: rtl/pkt_pkg.sv
// Shared packet definitions for the routing/clustering TX formatter and the receive-side parser.
// Packet type codes, byte lengths and the formatter FSM state type live here.
package pkt_pkg;

    localparam logic [7:0] PKT_HB   = 8'h01;
    localparam logic [7:0] PKT_QUPD = 8'h02;

    localparam int PKT_HB_LEN   = 5;
    localparam int PKT_QUPD_LEN = 15;
    localparam int CHK_LEN      = 1;

    // Word slots after the type byte: nodeID, hops, qValue, energy, hopsFromCH, chosenCH, chosenHop
    localparam int NUM_WORDS = 7;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } tx_state_t;

    function automatic logic isLegalType(input logic [7:0] t);
        return (t == PKT_HB) || (t == PKT_QUPD);
    endfunction

    function automatic logic [4:0] dataLen(input logic [7:0] t);
        return (t == PKT_HB) ? 5'(PKT_HB_LEN) : 5'(PKT_QUPD_LEN);
    endfunction

endpackage

// File: rtl/pkt_tx_fmb_if.sv
// Byte-stream handshake between the packet formatter (master) and the radio TX buffer (slave).
interface pkt_tx_fmb_if #(
    parameter int BYTE_WIDTH = 8
);
    logic [BYTE_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_last;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/pkt_tx_bytesel.sv
// Combinational byte picker: maps a byte index onto the snapshotted type byte and field words,
// big-endian (high byte of each word first).
module pkt_tx_bytesel
    import pkt_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int BYTE_WIDTH = 8
) (
    input  logic [7:0]                           pktType,
    input  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] words,
    input  logic [4:0]                           byteIdx,
    output logic [BYTE_WIDTH-1:0]                byteOut
);

    logic [4:0] offs;
    logic [3:0] wordSel;

    assign offs    = byteIdx - 5'd1;
    assign wordSel = offs[4:1];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        byteOut = '0;
        if (byteIdx == 5'd0) begin
            byteOut = pktType;
        end else begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (int'(wordSel) == w) begin
                    byteOut = offs[0] ? words[w][BYTE_WIDTH-1:0]
                                      : words[w][WORD_WIDTH-1 -: BYTE_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/pkt_tx_fmb.sv
// Transmit-side packet formatter: snapshots own routing fields on start and streams them as bytes.
// Optional trailing XOR checksum byte when PKT_TX_CHECKSUM_EN is defined.
module pkt_tx_fmb
    import pkt_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            pktType,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] myHops,
    input  logic [WORD_WIDTH-1:0] myQValue,
    input  logic [WORD_WIDTH-1:0] myEnergy,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] chosenHop,
    pkt_tx_fmb_if.master          txIf,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

`ifdef PKT_TX_CHECKSUM_EN
    localparam logic [4:0] CHK_BYTES = 5'(CHK_LEN);
`else
    localparam logic [4:0] CHK_BYTES = 5'd0;
`endif

    tx_state_t                           state;
    tx_state_t                           stateNext;
    logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] snapWords;
    logic [7:0]                          snapType;
    logic [4:0]                          byteIdx;
    logic [4:0]                          frameLen;
    logic [BYTE_WIDTH-1:0]               chkAcc;
    logic [BYTE_WIDTH-1:0]               selByte;
    logic [BYTE_WIDTH-1:0]               curByte;
    logic                                startOk;
    logic                                accept;
    logic                                isLast;
    logic                                errNext;

    assign startOk = (state == IDLE) && start && isLegalType(pktType);
    assign accept  = (state == SEND) && txIf.tx_ready;
    assign isLast  = (byteIdx == frameLen - 5'd1);

    pkt_tx_bytesel #(
        .WORD_WIDTH (WORD_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_bytesel (
        .pktType (snapType),
        .words   (snapWords),
        .byteIdx (byteIdx),
        .byteOut (selByte)
    );

`ifdef PKT_TX_CHECKSUM_EN
    // The final slot carries the XOR of everything already accepted.
    assign curByte = isLast ? chkAcc : selByte;
`else
    assign curByte = selByte;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            err       <= 1'b0;
            byteIdx   <= '0;
            frameLen  <= '0;
            chkAcc    <= '0;
            snapType  <= '0;
            // NOTE: the snapshot bank is plain registers, so it is cleared with everything else.
            snapWords <= '0;
        end else begin
            state <= stateNext;
            err   <= errNext;
            if (startOk) begin
                snapType  <= pktType;
                snapWords <= {chosenHop, chosenCH, hopsFromCH, myEnergy,
                              myQValue, myHops, myNodeID};
                frameLen  <= dataLen(pktType) + CHK_BYTES;
                byteIdx   <= '0;
                chkAcc    <= '0;
            end else if (accept) begin
                chkAcc <= chkAcc ^ curByte;
                if (!isLast) begin
                    byteIdx <= byteIdx + 5'd1;
                end
            end
        end
    end

    always_comb begin
        stateNext = state;
        errNext   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (isLegalType(pktType)) begin
                        stateNext = SEND;
                    end else begin
                        errNext = 1'b1;
                    end
                end
            end
            SEND: begin
                if (accept && isLast) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign txIf.tx_valid = (state == SEND);
    assign txIf.tx_last  = (state == SEND) && isLast;
    assign txIf.tx_data  = (state == SEND) ? curByte : '0;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

endmodule

// File: tb/tb_pkt_tx_fmb.sv
// Self-checking bench for pkt_tx_fmb: queue-based packet model checked every cycle plus literal byte vectors.
// Build with +define+PKT_TX_CHECKSUM_EN to exercise the checksum variant.
module tb_pkt_tx_fmb;
    import pkt_pkg::*;

    typedef logic [7:0] byteQ_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pktType = 8'h00;
    logic [15:0] myNodeID = '0, myHops = '0, myQValue = '0, myEnergy = '0;
    logic [15:0] hopsFromCH = '0, chosenCH = '0, chosenHop = '0;
    logic        busy, done, err;

    int checks = 0;
    int failures = 0;

    pkt_tx_fmb_if #(.BYTE_WIDTH(8)) txIf ();

    pkt_tx_fmb #(.WORD_WIDTH(16), .BYTE_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pktType    (pktType),
        .myNodeID   (myNodeID),
        .myHops     (myHops),
        .myQValue   (myQValue),
        .myEnergy   (myEnergy),
        .hopsFromCH (hopsFromCH),
        .chosenCH   (chosenCH),
        .chosenHop  (chosenHop),
        .txIf       (txIf),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model state and observation logs
    byteQ_t q;
    byteQ_t rxLog;
    bit     doneNow = 1'b0;
    bit     errNow = 1'b0;
    bit     chkEn = 1'b0;
    int     cyc = 0;
    int     doneCount = 0;
    int     errCount = 0;
    int     doneCyc = 0;
    int     lastIdx = 0;
    int     startCyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [15:0] w [7];
        logic [7:0]  x;
        bit          nd, ne, idle;
        if (chkEn) begin
            if (txIf.tx_valid === 1'b1 && txIf.tx_ready === 1'b1) begin
                rxLog.push_back(txIf.tx_data);
                if (txIf.tx_last === 1'b1) lastIdx = rxLog.size();
            end
            if (done === 1'b1) begin
                doneCount++;
                doneCyc = cyc;
            end
            if (err === 1'b1) errCount++;

            check("tx_valid", 32'(txIf.tx_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                check("tx_data", 32'(txIf.tx_data), 32'(q[0]));
                check("tx_last", 32'(txIf.tx_last), 32'(q.size() == 1));
            end
            check("busy", 32'(busy), 32'((q.size() > 0) || doneNow));
            check("done", 32'(done), 32'(doneNow));
            check("err", 32'(err), 32'(errNow));

            // Advance the model across the coming edge using the inputs now on the pins
            nd = 1'b0;
            ne = 1'b0;
            idle = (q.size() == 0) && !doneNow;
            if (rst) begin
                q.delete();
            end else if (q.size() > 0) begin
                if (txIf.tx_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) nd = 1'b1;
                end
            end else if (idle && start) begin
                if (pktType == PKT_HB || pktType == PKT_QUPD) begin
                    w = '{myNodeID, myHops, myQValue, myEnergy, hopsFromCH, chosenCH, chosenHop};
                    q.push_back(pktType);
                    for (int i = 0; i < ((pktType == PKT_HB) ? 2 : 7); i++) begin
                        q.push_back(w[i][15:8]);
                        q.push_back(w[i][7:0]);
                    end
`ifdef PKT_TX_CHECKSUM_EN
                    x = 8'h00;
                    foreach (q[i]) x ^= q[i];
                    q.push_back(x);
`endif
                end else begin
                    ne = 1'b1;
                end
            end
            doneNow = nd;
            errNow = ne;
        end
    end

    task automatic setFields(input logic [15:0] id, hops, qv, en, hch, ch, hop);
        myNodeID = id; myHops = hops; myQValue = qv; myEnergy = en;
        hopsFromCH = hch; chosenCH = ch; chosenHop = hop;
    endtask

    task automatic startNow(input logic [7:0] t);
        pktType = t;
        start = 1'b1;
        startCyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic sendStart(input logic [7:0] t);
        @(posedge clk);
        #1 startNow(t);
    endtask

    task automatic waitDone(input int budget, input string name);
        int d0 = doneCount;
        int n = 0;
        while (doneCount == d0 && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        check(name, 32'(doneCount != d0), 32'd1);
    endtask

    task automatic checkLog(input string name, input byteQ_t exp);
        check({name, "_len"}, 32'(rxLog.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < rxLog.size(); i++)
            check($sformatf("%s_b%0d", name, i), 32'(rxLog[i]), 32'(exp[i]));
    endtask

    bit stopTog;

    initial begin
        byteQ_t hbExp;
        byteQ_t qExp;
        int e0;
        int n;
        hbExp = '{8'h01, 8'h00, 8'h19, 8'h00, 8'h02};
        qExp  = '{8'h02, 8'h00, 8'h19, 8'h00, 8'h02, 8'h40, 8'h00, 8'h30,
                  8'h00, 8'h00, 8'h02, 8'h00, 8'h19, 8'h00, 8'h41};
`ifdef PKT_TX_CHECKSUM_EN
        hbExp.push_back(8'h1A);
        qExp.push_back(8'h33);
`endif
        txIf.tx_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chkEn = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", 32'(txIf.tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // 1: heartbeat, one byte per cycle
        setFields(16'd25, 16'd2, 16'h4000, 16'h3000, 16'd2, 16'd25, 16'd65);
        rxLog.delete();
        lastIdx = 0;
        sendStart(PKT_HB);
        n = startCyc;
        waitDone(40, "t1_timeout");
        checkLog("t1", hbExp);
        check("t1_last_pos", 32'(lastIdx), 32'(hbExp.size()));
        check("t1_done_cyc", 32'(doneCyc - n), 32'(hbExp.size() + 1));

        // 2: Q update started in the cycle right after done
        rxLog.delete();
        startNow(PKT_QUPD);
        waitDone(60, "t2_timeout");
        checkLog("t2", qExp);
        check("t2_last_pos", 32'(lastIdx), 32'(qExp.size()));

        // 3: stalling sink and inputs scribbled mid-packet
        rxLog.delete();
        stopTog = 1'b0;
        fork
            begin
                while (!stopTog) begin
                    @(posedge clk);
                    #1 txIf.tx_ready = ~txIf.tx_ready;
                end
            end
            begin
                sendStart(PKT_QUPD);
                repeat (3) @(posedge clk);
                #1 setFields(16'hFFFF, 16'h1234, 16'h0, 16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0);
                pktType = 8'h07;
                waitDone(100, "t3_timeout");
                stopTog = 1'b1;
            end
        join
        txIf.tx_ready = 1'b1;
        checkLog("t3", qExp);

        // 4: start while busy is ignored; illegal type pulses err only
        setFields(16'd25, 16'd2, 16'h4000, 16'h3000, 16'd2, 16'd25, 16'd65);
        rxLog.delete();
        sendStart(PKT_QUPD);
        repeat (2) @(posedge clk);
        #1 startNow(PKT_HB);
        waitDone(60, "t4_timeout");
        checkLog("t4_pkt", qExp);
        e0 = errCount;
        rxLog.delete();
        sendStart(8'h07);
        repeat (3) @(posedge clk);
        #1 check("t4_err_cnt", 32'(errCount - e0), 32'd1);
        check("t4_no_bytes", 32'(rxLog.size()), 32'd0);

        // 5: reset in the middle of a Q update, then a clean heartbeat
        rxLog.delete();
        sendStart(PKT_QUPD);
        n = 0;
        while (rxLog.size() < 7 && n < 60) begin
            @(posedge clk);
            #1 n++;
        end
        check("t5_reach_byte7", 32'(rxLog.size() >= 7), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t5_valid", 32'(txIf.tx_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        rxLog.delete();
        repeat (3) @(posedge clk);
        #1 check("t5_no_tail", 32'(rxLog.size()), 32'd0);
        sendStart(PKT_HB);
        waitDone(40, "t5_timeout");
        checkLog("t5_hb", hbExp);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
